// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the divider arbiter slice.
// Macro DIV_ARB_ZERO_BYPASS_EN enables divide-by-zero bypass in div_arbiter.
package div_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    // Replicated to W bits to form the all-ones divide-by-zero quotient
    localparam logic DIV0_QUO_BIT = 1'b1;

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] win_id,
    output logic          any
);

    logic [IW-1:0] w_idx;

    always_comb begin
        win_id = '0;
        any    = 1'b0;
        w_idx  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_idx = IW'((32'(ptr) + i) % N);
            if (!any && req[w_idx]) begin
                any    = 1'b1;
                win_id = w_idx;
            end
        end
        win = any ? (N'(1) << win_id) : '0;
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sequencer sharing one sequential divider among N requesters.
// Macro DIV_ARB_ZERO_BYPASS_EN: divisor 0 skips the divider and adds output err_div0.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int IW = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] dvnd_in,
    input  logic [N*W-1:0] dvsr_in,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   resp_valid,
    output logic [W-1:0]   quo_out,
    output logic [W-1:0]   rmd_out,
    output logic [IW-1:0]  resp_id,
    output logic           busy,
    output logic           div_str_trg,
    output logic [W-1:0]   div_dvnd,
    output logic [W-1:0]   div_dvsr,
    input  logic           div_ready,
    input  logic           div_done_trg,
    input  logic [W-1:0]   div_quo,
    input  logic [W-1:0]   div_rmd
`ifdef DIV_ARB_ZERO_BYPASS_EN
    ,
    output logic           err_div0
`endif
);

    state_t        r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_cur_id;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  r_resp_valid;
    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_rmd;
    logic [IW-1:0] r_resp_id;
    logic [W-1:0]  r_div_dvnd;
    logic [W-1:0]  r_div_dvsr;

    logic [N-1:0]  w_win;
    logic [IW-1:0] w_win_id;
    logic          w_any;
    logic [IW-1:0] w_ptr_nxt;
    logic [W-1:0]  w_sel_dvnd;
    logic [W-1:0]  w_sel_dvsr;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_ptr),
        .win    (w_win),
        .win_id (w_win_id),
        .any    (w_any)
    );

    always_comb begin
        w_sel_dvnd = '0;
        w_sel_dvsr = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_win[i]) begin
                w_sel_dvnd = dvnd_in[i*W +: W];
                w_sel_dvsr = dvsr_in[i*W +: W];
            end
        end
    end

    assign w_ptr_nxt = (w_win_id == IW'(N - 1)) ? '0 : w_win_id + 1'b1;

`ifdef DIV_ARB_ZERO_BYPASS_EN
    logic r_err_div0;
    assign err_div0 = r_err_div0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_cur_id     <= '0;
            r_gnt        <= '0;
            r_resp_valid <= '0;
            r_quo        <= '0;
            r_rmd        <= '0;
            r_resp_id    <= '0;
            r_div_dvnd   <= '0;
            r_div_dvsr   <= '0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
            r_err_div0   <= 1'b0;
`endif
        end else begin
            r_gnt        <= '0;
            r_resp_valid <= '0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
            r_err_div0   <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_any && div_ready) begin
                        r_gnt    <= w_win;
                        r_cur_id <= w_win_id;
                        r_ptr    <= w_ptr_nxt;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                        // Zero divisor answers directly, grant and response land together
                        if (w_sel_dvsr == '0) begin
                            r_quo        <= {W{DIV0_QUO_BIT}};
                            r_rmd        <= w_sel_dvnd;
                            r_resp_id    <= w_win_id;
                            r_resp_valid <= w_win;
                            r_err_div0   <= 1'b1;
                            r_state      <= RESP;
                        end else begin
                            r_div_dvnd <= w_sel_dvnd;
                            r_div_dvsr <= w_sel_dvsr;
                            r_state    <= START;
                        end
`else
                        r_div_dvnd <= w_sel_dvnd;
                        r_div_dvsr <= w_sel_dvsr;
                        r_state    <= START;
`endif
                    end
                end
                START: r_state <= WAIT;
                WAIT: begin
                    if (div_done_trg) begin
                        r_quo        <= div_quo;
                        r_rmd        <= div_rmd;
                        r_resp_id    <= r_cur_id;
                        r_resp_valid <= N'(1) << r_cur_id;
                        r_state      <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign resp_valid  = r_resp_valid;
    assign quo_out     = r_quo;
    assign rmd_out     = r_rmd;
    assign resp_id     = r_resp_id;
    assign div_dvnd    = r_div_dvnd;
    assign div_dvsr    = r_div_dvsr;
    assign busy        = (r_state != IDLE);
    assign div_str_trg = (r_state == START);

endmodule
